// File: rtl/ram_mp.sv
// Multi-port byte-addressed RAM with per-port wait-state FSMs and a base-address window.
// Each port completes with a one-cycle ready (in window) or error (out of window) pulse.
//
// state  | meaning
// S_IDLE | no request in flight, outputs low
// S_WAIT | request accepted, counting down wait cycles
// S_RESP | response cycle: ready/error asserted, write commits at the closing edge
module ram_mp #(
    parameter int          ADDR_WIDTH = 22,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          NPORTS     = 2,
    parameter int          LATENCY    = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NPORTS*32-1:0]  mem_address,
    input  logic [NPORTS*32-1:0]  mem_wdata,
    input  logic [NPORTS*4-1:0]   mem_wsel,
    input  logic [NPORTS-1:0]     mem_valid,
    output logic [NPORTS*32-1:0]  mem_rdata,
    output logic [NPORTS-1:0]     mem_ready,
    output logic [NPORTS-1:0]     mem_error
);

    localparam int IW    = ADDR_WIDTH - 2;
    localparam int WORDS = 2 ** IW;

    logic [31:0]     mem [WORDS];
    logic [NPORTS-1:0] resp;
    logic [NPORTS-1:0] in_win;
    logic [IW-1:0]   idx [NPORTS];

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        logic unused_addr_lsb;

        assign unused_addr_lsb = ^mem_address[32*p +: 2];
        assign idx[p]          = mem_address[32*p+2 +: IW];
        assign in_win[p]       = (mem_address[32*p+ADDR_WIDTH +: 32-ADDR_WIDTH]
                                  == BASE_ADDR[31:ADDR_WIDTH]);
        assign mem_ready[p]    = resp[p] & in_win[p];
        assign mem_error[p]    = resp[p] & ~in_win[p];
        assign mem_rdata[32*p +: 32] = mem_ready[p] ? mem[idx[p]] : 32'h0;

        if (LATENCY == 0) begin : g_comb
            // Purely combinational path; rstn gating keeps outputs low in reset.
            assign resp[p] = mem_valid[p] & rstn;
        end else begin : g_fsm
            typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

            state_t     state;
            state_t     state_nx;
            logic [3:0] cnt;
            logic [3:0] cnt_nx;
            logic       resp_l;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    state <= S_IDLE;
                    cnt   <= 4'd0;
                end else begin
                    state <= state_nx;
                    cnt   <= cnt_nx;
                end
            end

            // WAIT hands over to RESP when cnt reaches 1 so the response
            // lands exactly LATENCY cycles after acceptance.
            always_comb begin
                state_nx = state;
                cnt_nx   = cnt;
                case (state)
                    S_IDLE: begin
                        if (mem_valid[p]) begin
                            cnt_nx   = 4'(LATENCY - 1);
                            state_nx = (LATENCY == 1) ? S_RESP : S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (!mem_valid[p]) begin
                            state_nx = S_IDLE;
                        end else if (cnt == 4'd1) begin
                            state_nx = S_RESP;
                        end else begin
                            cnt_nx = cnt - 4'd1;
                        end
                    end
                    S_RESP:  state_nx = S_IDLE;
                    default: state_nx = S_IDLE;
                endcase
            end

            always_comb begin
                resp_l = 1'b0;
                if (state == S_RESP) begin
                    resp_l = mem_valid[p];
                end
            end

            assign resp[p] = resp_l;
        end
    end

    // Highest port is applied first so the lowest port index wins a byte collision.
    always_ff @(posedge clk) begin
        for (int p = NPORTS - 1; p >= 0; p--) begin
            if (mem_ready[p]) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wsel[4*p+b]) begin
                        mem[idx[p]][8*b +: 8] <= mem_wdata[32*p+8*b +: 8];
                    end
                end
            end
        end
    end

endmodule
